ram_arbiter: RTL and testbench

Two-port arbiter that shares one single-port block RAM between two independent requesters, for example a character-generator read port and a host write port. It sits directly in front of the RAM: it drives the address, write-enable and write-data inputs, and receives the RAM's registered read data. It grants one access per cycle using round-robin order with an optional per-port lock for bursts, and returns a read-valid strobe to the port that issued each read.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arbiter_rr_pick2.sv | 23 ++
 rtl/ram_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   arb_state_e : arbiter FSM state encoding
//   PORT0/PORT1 : port index constants, used for last-grant and read tagging
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-input round-robin picker.
//   req[1:0] : request vector (bit N = port N)
//   last     : index of the port granted most recently
//   gnt[1:0] : one-hot grant; on a tie the port not granted last wins
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM (1-cycle registered read, read-before-write)
// between two requesters, one access per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RR    | round-robin between both ports
// ST_LOCK0 | port 0 owns the RAM for a burst; port 1 waits
// ST_LOCK1 | port 1 owns the RAM for a burst; port 0 waits
//
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   pN_req/we/lock/addr/wdata     : port N request and access fields
//   pN_gnt                        : combinational accept of port N's request
//   pN_rvalid, pN_rdata           : read return for port N (rdata = ram_dout)
//   ram_addr, ram_we, ram_din     : RAM controls, muxed from the granted port
//   ram_dout                      : registered RAM read data
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [addr_width-1:0] p0_addr,
  input  logic [data_width-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [data_width-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [addr_width-1:0] p1_addr,
  input  logic [data_width-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [data_width-1:0] p1_rdata,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_we,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  arb_state_e            state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_tag_q, rd_tag_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [1:0]            rr_gnt;
  logic [1:0]            gnt;

  rr_pick2 u_pick (
    .req  ({p1_req, p0_req}),
    .last (last_gnt_q),
    .gnt  (rr_gnt)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rd_pend_d  = 1'b0;
    rd_tag_d   = rd_tag_q;
    addr_d     = addr_q;
    gnt        = 2'b00;

    // A locked port keeps the RAM; if it drops its request the other port
    // is served in the same cycle so the release costs no bubble.
    case (state_q)
      ST_LOCK0: gnt = p0_req ? 2'b01 : (p1_req ? 2'b10 : 2'b00);
      ST_LOCK1: gnt = p1_req ? 2'b10 : (p0_req ? 2'b01 : 2'b00);
      default:  gnt = rr_gnt;
    endcase

    // Requests are ignored while reset is asserted.
    if (!rstn) gnt = 2'b00;

    if (gnt[0]) begin
      addr_d     = p0_addr;
      last_gnt_d = PORT0;
      rd_pend_d  = ~p0_we;
      rd_tag_d   = PORT0;
      state_d    = p0_lock ? ST_LOCK0 : ST_RR;
    end else if (gnt[1]) begin
      addr_d     = p1_addr;
      last_gnt_d = PORT1;
      rd_pend_d  = ~p1_we;
      rd_tag_d   = PORT1;
      state_d    = p1_lock ? ST_LOCK1 : ST_RR;
    end else begin
      state_d    = ST_RR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RR;
      last_gnt_q <= PORT1;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= PORT0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
      addr_q     <= addr_d;
    end
  end

  // With no grant the address holds the last granted value.
  assign ram_addr  = addr_d;
  assign ram_we    = (gnt[0] & p0_we) | (gnt[1] & p1_we);
  assign ram_din   = gnt[1] ? p1_wdata : p0_wdata;

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rd_pend_q & (rd_tag_q == PORT0);
  assign p1_rvalid = rd_pend_q & (rd_tag_q == PORT1);
  assign p0_rdata  = ram_dout;
  assign p1_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_we;

  always #5 clk = ~clk;

  ram_arbiter #(.addr_width(8), .data_width(8)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Attached RAM: registered read, read-before-write, plus a preload port.
  logic [7:0] mem [0:255];
  logic       tb_wr_en = 1'b0;
  logic [7:0] tb_wr_addr = 8'h00, tb_wr_data = 8'h00;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, who went last, what read is in flight.
  int         m_lock, m_last, m_tag;
  bit         m_pend;
  logic [7:0] m_rexp, m_addr_last;
  logic [7:0] shadow [0:255];
  int         exp_g, obs_g;

  bit         s_req [2], s_we [2], s_lock [2];
  logic [7:0] s_addr [2], s_wdata [2];

  task automatic model_reset();
    m_lock = -1; m_last = 1; m_pend = 0; m_tag = 0; m_addr_last = 8'h00;
  endtask

  task automatic drive();
    p0_req = s_req[0]; p0_we = s_we[0]; p0_lock = s_lock[0];
    p0_addr = s_addr[0]; p0_wdata = s_wdata[0];
    p1_req = s_req[1]; p1_we = s_we[1]; p1_lock = s_lock[1];
    p1_addr = s_addr[1]; p1_wdata = s_wdata[1];
  endtask

  task automatic clear_reqs();
    for (int n = 0; n < 2; n++) begin
      s_req[n] = 0; s_we[n] = 0; s_lock[n] = 0;
    end
  endtask

  task automatic set_port(input int n, input bit we, input bit lk,
                          input logic [7:0] a, input logic [7:0] d);
    s_req[n] = 1; s_we[n] = we; s_lock[n] = lk; s_addr[n] = a; s_wdata[n] = d;
  endtask

  // One clock cycle: drive, check combinational and returned values mid-cycle,
  // then advance the model across the rising edge.
  task automatic step();
    logic [7:0] e_addr;
    bit         e_we;
    drive();
    @(negedge clk);
    exp_g = -1;
    if (m_lock >= 0) begin
      if (s_req[m_lock]) exp_g = m_lock;
      else if (s_req[1 - m_lock]) exp_g = 1 - m_lock;
    end else if (s_req[0] && s_req[1]) exp_g = 1 - m_last;
    else if (s_req[0]) exp_g = 0;
    else if (s_req[1]) exp_g = 1;
    obs_g = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
    e_we   = (exp_g >= 0) ? s_we[exp_g] : 1'b0;
    e_addr = (exp_g >= 0) ? s_addr[exp_g] : m_addr_last;
    chk("p0_gnt", p0_gnt, exp_g == 0);
    chk("p1_gnt", p1_gnt, exp_g == 1);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    if (e_we) chk("ram_din", ram_din, s_wdata[exp_g]);
    chk("p0_rvalid", p0_rvalid, m_pend && m_tag == 0);
    chk("p1_rvalid", p1_rvalid, m_pend && m_tag == 1);
    if (m_pend) chk("rdata", (m_tag == 0) ? p0_rdata : p1_rdata, m_rexp);
    @(posedge clk);
    if (exp_g >= 0) begin
      m_last = exp_g;
      m_addr_last = s_addr[exp_g];
      if (s_we[exp_g]) begin
        shadow[s_addr[exp_g]] = s_wdata[exp_g];
        m_pend = 0;
      end else begin
        m_pend = 1;
        m_tag = exp_g;
        m_rexp = shadow[s_addr[exp_g]];
      end
      m_lock = s_lock[exp_g] ? exp_g : -1;
    end else begin
      m_pend = 0;
      m_lock = -1;
    end
    #1;
  endtask

  initial begin
    model_reset();
    clear_reqs();
    for (int n = 0; n < 2; n++) begin
      s_addr[n] = 8'h00; s_wdata[n] = 8'h00;
    end
    // Requests asserted during reset must be ignored.
    s_req[0] = 1; s_req[1] = 1;
    drive();

    for (int i = 0; i < 256; i++) begin
      tb_wr_en = 1'b1;
      tb_wr_addr = 8'(i);
      tb_wr_data = (i == 16) ? 8'hA5 : (8'(i) ^ 8'h5A);
      shadow[i] = tb_wr_data;
      @(posedge clk); #1;
    end
    tb_wr_en = 1'b0;

    @(negedge clk);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rdata", p0_rdata, ram_dout);
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_reqs();

    // Single read of 0xA5 at 0x10.
    set_port(0, 0, 0, 8'h10, 8'h00);
    step();
    chk("rd_gnt", obs_g, 0);
    clear_reqs();
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 8'hA5);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    step();

    // Make port 1 most recent, then a continuous tie.
    set_port(1, 0, 0, 8'h02, 8'h00);
    step();
    set_port(0, 0, 0, 8'h01, 8'h00);
    set_port(1, 0, 0, 8'h02, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_order", obs_g, k % 2);
    end
    clear_reqs();
    step();

    // Lock burst: port 0 goes first so port 1 wins the following tie.
    set_port(0, 0, 0, 8'h30, 8'h00);
    step();
    for (int k = 0; k < 4; k++) begin
      set_port(0, 0, 0, 8'h40, 8'h00);
      set_port(1, 1, k < 3, 8'h20 + 8'(k), 8'($urandom));
      step();
      chk("burst_p1_owns", obs_g, 1);
    end
    s_req[1] = 0;
    step();
    chk("burst_p0_after", obs_g, 0);
    clear_reqs();
    step();

    // Lock release by dropping the request.
    set_port(0, 0, 1, 8'h07, 8'h00);
    step();
    chk("lk_p0", obs_g, 0);
    s_req[0] = 0;
    set_port(1, 0, 0, 8'h08, 8'h00);
    step();
    chk("lk_release_p1", obs_g, 1);
    set_port(0, 0, 0, 8'h09, 8'h00);
    step();
    chk("lk_back_to_rr", obs_g, 0);
    clear_reqs();
    step();

    // Write then read back.
    set_port(0, 1, 0, 8'h05, 8'h3C);
    step();
    chk("wr_no_rvalid", p0_rvalid, 0);
    set_port(0, 0, 0, 8'h05, 8'h00);
    step();
    chk("wrrd_rvalid", p0_rvalid, 1);
    chk("wrrd_rdata", p0_rdata, 8'h3C);
    clear_reqs();
    step();

    // Asynchronous reset while a read is in flight.
    set_port(0, 0, 0, 8'h10, 8'h00);
    step();
    rstn = 1'b0;
    #1;
    chk("mid_rst_p0_rvalid", p0_rvalid, 0);
    chk("mid_rst_p1_rvalid", p1_rvalid, 0);
    model_reset();
    set_port(0, 0, 0, 8'h11, 8'h00);
    set_port(1, 0, 0, 8'h12, 8'h00);
    drive();
    @(negedge clk);
    chk("mid_rst_p0_gnt", p0_gnt, 0);
    chk("mid_rst_p1_gnt", p1_gnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    chk("post_rst_tie", obs_g, 0);
    step();
    chk("post_rst_alt", obs_g, 1);
    clear_reqs();
    step();

    // Randomized traffic; a waiting request holds its fields until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!s_req[n]) begin
          if ($urandom_range(0, 3) != 0)
            set_port(n, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     8'($urandom_range(0, 15)), 8'($urandom));
          else begin
            s_we[n] = 0; s_lock[n] = 0;
          end
        end
      end
      step();
      if (exp_g >= 0) s_req[exp_g] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
